// File: rtl/bbs_gen.sv
// Blum-Blum-Shub generator: bit-serial p*q modulus build, then N bit-serial
// modular squarings x <- x*x mod m, harvesting K LSBs of x per squaring.
module bbs_gen #(
   parameter int PQ_W  = 32,
   parameter int OUT_W = 32,
   parameter int K     = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                keep_m,
   input  logic                use_xnext,
   input  logic [PQ_W-1:0]     p,
   input  logic [PQ_W-1:0]     q,
   input  logic [PQ_W-1:0]     seed,
   output logic                ready,
   output logic [2*PQ_W-1:0]   m,
   output logic                m_valid,
   output logic [OUT_W-1:0]    result,
   output logic                result_valid,
   input  logic                result_ready,
   output logic                cfg_err
);
   localparam int M_W = 2 * PQ_W;
   localparam int N   = OUT_W / K;
   localparam int BW  = $clog2(M_W);
   localparam int NW  = $clog2(N + 1);

   if ((K < 1) || (K > PQ_W) || ((OUT_W % K) != 0)) begin : g_param_chk
      $error("bbs_gen: K must satisfy 1 <= K <= PQ_W and OUT_W %% K == 0");
   end

   typedef enum logic [2:0] {IDLE, MUL, CHECK, SQR, HOLD} state_t;

   state_t           state_q;
   logic             ready_q, m_valid_q, result_valid_q, cfg_err_q;
   logic [M_W-1:0]   m_q, x_q, mcand_q;
   logic [PQ_W-1:0]  mplier_q, seed_q;
   logic [M_W+1:0]   r_q;
   logic [OUT_W-1:0] word_q, result_q;
   logic [BW-1:0]    bit_q;
   logic [NW-1:0]    sq_q;

   logic [M_W+1:0]   m_ext, dbl, dbl_red, add, r_d;
   logic [OUT_W-1:0] word_d;
   logic             seed_in_bad, seed_q_bad, m_small;

   // One MSB-first step of r = r*x mod m; both partial sums stay below 2m.
   always_comb begin
      m_ext   = {2'b00, m_q};
      dbl     = r_q << 1;
      dbl_red = (dbl >= m_ext) ? (dbl - m_ext) : dbl;
      add     = x_q[bit_q] ? (dbl_red + {2'b00, x_q}) : dbl_red;
      r_d     = (add >= m_ext) ? (add - m_ext) : add;
      word_d  = (word_q << K) | OUT_W'(r_d[K-1:0]);
      seed_in_bad = (seed == '0)   || ({{PQ_W{1'b0}}, seed}   >= m_q);
      seed_q_bad  = (seed_q == '0) || ({{PQ_W{1'b0}}, seed_q} >= m_q);
      m_small     = (m_q < M_W'(3));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         ready_q        <= 1'b1;
         m_q            <= '0;
         m_valid_q      <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         cfg_err_q      <= 1'b0;
         x_q            <= '0;
         mcand_q        <= '0;
         mplier_q       <= '0;
         seed_q         <= '0;
         r_q            <= '0;
         word_q         <= '0;
         bit_q          <= '0;
         sq_q           <= '0;
      end else begin
         cfg_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (!keep_m) begin
                     state_q   <= MUL;
                     ready_q   <= 1'b0;
                     m_valid_q <= 1'b0;
                     x_q       <= '0;
                     m_q       <= '0;
                     mcand_q   <= {{PQ_W{1'b0}}, p};
                     mplier_q  <= q;
                     seed_q    <= seed;
                     bit_q     <= BW'(PQ_W - 1);
                  end else if (!m_valid_q || (!use_xnext && seed_in_bad)) begin
                     cfg_err_q <= 1'b1;
                  end else begin
                     if (!use_xnext) x_q <= {{PQ_W{1'b0}}, seed};
                     state_q <= SQR;
                     ready_q <= 1'b0;
                     r_q     <= '0;
                     bit_q   <= BW'(M_W - 1);
                     sq_q    <= '0;
                  end
               end
            end
            MUL: begin
               m_q      <= m_q + (mplier_q[0] ? mcand_q : '0);
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               if (bit_q == '0) state_q <= CHECK;
               else bit_q <= bit_q - 1'b1;
            end
            CHECK: begin
               if (m_small || seed_q_bad) begin
                  cfg_err_q <= 1'b1;
                  state_q   <= IDLE;
                  ready_q   <= 1'b1;
               end else begin
                  m_valid_q <= 1'b1;
                  x_q       <= {{PQ_W{1'b0}}, seed_q};
                  state_q   <= SQR;
                  r_q       <= '0;
                  bit_q     <= BW'(M_W - 1);
                  sq_q      <= '0;
               end
            end
            SQR: begin
               if (bit_q == '0) begin
                  x_q    <= r_d[M_W-1:0];
                  r_q    <= '0;
                  bit_q  <= BW'(M_W - 1);
                  word_q <= word_d;
                  if (sq_q == NW'(N - 1)) begin
                     result_q       <= word_d;
                     result_valid_q <= 1'b1;
                     state_q        <= HOLD;
                  end else begin
                     sq_q <= sq_q + 1'b1;
                  end
               end else begin
                  r_q   <= r_d;
                  bit_q <= bit_q - 1'b1;
               end
            end
            HOLD: begin
               if (result_ready) begin
                  result_valid_q <= 1'b0;
                  state_q        <= IDLE;
                  ready_q        <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign ready        = ready_q;
   assign m            = m_q;
   assign m_valid      = m_valid_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign cfg_err      = cfg_err_q;
endmodule
